mlblock_config_loader: RTL and testbench

// - Drives the serial configuration chain of an MLBlock column from a parallel config word:

---
 rtl/mlblock_cfg_pkg.sv | 18 +
 rtl/mlblock_config_loader.sv | 88 ++++++++
 tb/tb_mlblock_config_loader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mlblock_cfg_pkg.sv
// Shared types and helpers for the MLBlock configuration chain loader.
package mlblock_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      VER  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Chain length of one column: block conf registers followed by every MAC unit's conf bits.
   function automatic int chain_len(input int i_s_log2, input int i_d_log2,
                                    input int res_d_log2, input int mac_units,
                                    input int mac_conf_bits);
      return i_s_log2 + i_d_log2 + res_d_log2 + mac_units * mac_conf_bits;
   endfunction

endpackage

// File: rtl/mlblock_config_loader.sv
// Serialises a parallel config word into an MLBlock configuration chain, MSB first,
// and optionally re-sends it while comparing the chain tail to prove the load.
module mlblock_config_loader
   import mlblock_cfg_pkg::*;
#(
   parameter int CHAIN_LEN = 32,
   parameter int VERIFY    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [CHAIN_LEN-1:0] cfg_word,
   input  logic                 stall,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic                 config_en,
   output logic                 config_in,
   input  logic                 config_out
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);

   state_t               state, nxt;
   logic [CHAIN_LEN-1:0] word;    // rotates once per shift, so it is back in place after each pass
   logic [CNT_W-1:0]     cnt;     // bits issued in the current pass
   logic                 vfy_q;   // the bit now on config_in belongs to the verify pass
   logic                 accept;
   logic                 shift;
   logic                 last;

   assign last = (cnt == CNT_W'(CHAIN_LEN - 1));

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nxt;
   end

   // Next-state logic: a pass ends when its final bit is issued
   always_comb begin
      nxt = state;
      case (state)
         IDLE: if (start) nxt = LOAD;
         LOAD: if (shift && last) nxt = (VERIFY != 0) ? VER : DONE;
         VER:  if (shift && last) nxt = DONE;
         DONE: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Output/control decode; busy spans DONE so it drops on the same edge done rises
   always_comb begin
      busy   = (state != IDLE);
      accept = (state == IDLE) && start;
      shift  = ((state == LOAD) || (state == VER)) && !stall;
   end

   // Datapath: word rotate, bit counter, registered chain drive and tail compare
   always_ff @(posedge clk) begin
      if (reset) begin
         word      <= '0;
         cnt       <= '0;
         vfy_q     <= 1'b0;
         config_en <= 1'b0;
         config_in <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         done      <= (state == DONE);
         config_en <= shift;
         if (shift) begin
            config_in <= word[CHAIN_LEN-1];
            word      <= {word[CHAIN_LEN-2:0], word[CHAIN_LEN-1]};
            vfy_q     <= (state == VER);
            cnt       <= last ? '0 : cnt + 1'b1;
         end
         // During verify the tail shows the same bit that is being re-sent
         if (config_en && vfy_q && (config_out != config_in)) error <= 1'b1;
         if (accept) begin
            word  <= cfg_word;
            cnt   <= '0;
            error <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mlblock_config_loader.sv
// Bench for mlblock_config_loader: two instances (single pass and verify) drive
// behavioural shift-chain models; a scoreboard checks every bit put on config_in.
module tb_mlblock_config_loader;
   import mlblock_cfg_pkg::*;

   localparam int N = chain_len(2, 2, 2, 1, 2);   // 8-bit chain

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         stall = 1'b0;
   logic [N-1:0] cfg_word = '0;
   logic         busy0, done0, error0, en0, in0, out0;
   logic         busy1, done1, error1, en1, in1, out1;
   logic [N-1:0] chain0 = '0, chain1 = '0;
   logic         stuck = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   bit q0[$];
   bit q1[$];
   bit e0, e1;

   // observations gathered while a load runs
   int   obs_lat0, obs_lat1, obs_lo0, obs_en1, obs_done_n0;
   logic obs_err_ver1, obs_err_done1, obs_busy_done0, obs_hold_ok;

   always #5 clk = ~clk;

   mlblock_config_loader #(.CHAIN_LEN(N), .VERIFY(0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .cfg_word(cfg_word), .stall(stall),
      .busy(busy0), .done(done0), .error(error0), .config_en(en0), .config_in(in0),
      .config_out(out0));

   mlblock_config_loader #(.CHAIN_LEN(N), .VERIFY(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .cfg_word(cfg_word), .stall(stall),
      .busy(busy1), .done(done1), .error(error1), .config_en(en1), .config_in(in1),
      .config_out(out1));

   // chain models: position 0 next to config_in, tail is position N-1
   always @(posedge clk) begin
      if (en0) chain0 <= {chain0[N-2:0], in0};
      if (en1) chain1 <= {chain1[N-2:0], in1};
   end
   assign out0 = chain0[N-1];
   assign out1 = stuck ? 1'b0 : chain1[N-1];

   // scoreboard: pop the expected bit whenever a DUT presents one
   always @(negedge clk) begin
      if (!reset && en0) begin
         n_cmp++;
         if (q0.size() == 0) begin
            n_bad++;
            $display("FAIL sb0_extra: config_in=%0b shifted with nothing expected", in0);
         end else begin
            e0 = q0.pop_front();
            if (in0 !== e0) begin
               n_bad++;
               $display("FAIL sb0_bit: config_in=%0b expected %0b", in0, e0);
            end
         end
      end
      if (!reset && en1) begin
         n_cmp++;
         if (q1.size() == 0) begin
            n_bad++;
            $display("FAIL sb1_extra: config_in=%0b shifted with nothing expected", in1);
         end else begin
            e1 = q1.pop_front();
            if (in1 !== e1) begin
               n_bad++;
               $display("FAIL sb1_bit: config_in=%0b expected %0b", in1, e1);
            end
         end
      end
   end

   // one-cycle start pulse; queue the MSB-first bit stream each DUT should emit
   task automatic pulse(input logic [N-1:0] w);
      @(negedge clk);
      cfg_word = w;
      start    = 1'b1;
      for (int i = N - 1; i >= 0; i--) q0.push_back(w[i]);
      for (int p = 0; p < 2; p++)
         for (int i = N - 1; i >= 0; i--) q1.push_back(w[i]);
      @(negedge clk);
      start    = 1'b0;
      cfg_word = '0;
   endtask

   // run until both DUTs finish; optional 3-cycle stall once dut0 has shifted stall_at bits
   task automatic observe(input int stall_at);
      int   en_n0, st_cnt;
      bit   stalled;
      logic last_in;
      obs_lat0 = -1; obs_lat1 = -1; obs_lo0 = 0; obs_en1 = 0; obs_done_n0 = 0;
      obs_err_ver1 = 1'bx; obs_err_done1 = 1'bx; obs_busy_done0 = 1'bx; obs_hold_ok = 1'b1;
      en_n0 = 0; st_cnt = 0; stalled = 0; last_in = in0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk); #1;
         if (en0) begin
            en_n0++;
            last_in = in0;
         end else if (obs_lat0 < 0 && !done0) begin
            obs_lo0++;
            if (in0 !== last_in) obs_hold_ok = 1'b0;
         end
         if (en1) obs_en1++;
         if (done0) begin
            obs_done_n0++;
            if (obs_lat0 < 0) begin obs_lat0 = c; obs_busy_done0 = busy0; end
         end
         if (done1 && obs_lat1 < 0) begin obs_lat1 = c; obs_err_done1 = error1; end
         if (c == N + 2) obs_err_ver1 = error1;
         if (stall_at != 0 && en_n0 == stall_at && !stalled) begin
            stall = 1'b1; stalled = 1; st_cnt = 0;
         end else if (stall) begin
            st_cnt++;
            if (st_cnt == 3) stall = 1'b0;
         end
         if (obs_lat0 >= 0 && obs_lat1 >= 0 && c >= obs_lat1 + 2) break;
      end
      stall = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;          // start during reset must be lost
      repeat (3) @(negedge clk);
      n_cmp++; if ({busy0, done0, error0, en0, in0} !== 5'b0) begin n_bad++;
         $display("FAIL reset0: outs=%b required 00000", {busy0, done0, error0, en0, in0}); end
      n_cmp++; if ({busy1, done1, error1, en1, in1} !== 5'b0) begin n_bad++;
         $display("FAIL reset1: outs=%b required 00000", {busy1, done1, error1, en1, in1}); end
      reset = 1'b0;
      start = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin n_bad++;
         $display("FAIL reset_start_lost: busy=%b%b required 00", busy0, busy1); end
   endtask

   task automatic test_load(input logic [N-1:0] w);
      pulse(w);
      n_cmp++; if (busy0 !== 1'b1 || busy1 !== 1'b1) begin n_bad++;
         $display("FAIL busy_rise %h: busy=%b%b required 11", w, busy0, busy1); end
      n_cmp++; if (error1 !== 1'b0) begin n_bad++;
         $display("FAIL err_clear %h: error=%b required 0", w, error1); end
      observe(0);
      n_cmp++; if (obs_lat0 != N + 1) begin n_bad++;
         $display("FAIL lat0 %h: %0d required %0d", w, obs_lat0, N + 1); end
      n_cmp++; if (obs_lat1 != 2 * N + 1) begin n_bad++;
         $display("FAIL lat1 %h: %0d required %0d", w, obs_lat1, 2 * N + 1); end
      n_cmp++; if (obs_en1 != 2 * N) begin n_bad++;
         $display("FAIL en_count1 %h: %0d required %0d", w, obs_en1, 2 * N); end
      n_cmp++; if (obs_done_n0 != 1) begin n_bad++;
         $display("FAIL done_width %h: %0d cycles required 1", w, obs_done_n0); end
      n_cmp++; if (obs_busy_done0 !== 1'b0) begin n_bad++;
         $display("FAIL busy_at_done %h: %b required 0", w, obs_busy_done0); end
      n_cmp++; if (chain0 !== w || chain1 !== w) begin n_bad++;
         $display("FAIL chain %h: model0=%h model1=%h", w, chain0, chain1); end
      n_cmp++; if (obs_err_done1 !== 1'b0 || error0 !== 1'b0) begin n_bad++;
         $display("FAIL no_error %h: error1=%b error0=%b required 0", w, obs_err_done1, error0); end
      n_cmp++; if (q0.size() != 0 || q1.size() != 0) begin n_bad++;
         $display("FAIL sb_drain %h: %0d/%0d bits never shifted", w, q0.size(), q1.size()); end
   endtask

   task automatic test_verify_stuck();
      stuck = 1'b1;
      pulse(8'hFF);
      observe(0);
      n_cmp++; if (obs_err_ver1 !== 1'b1) begin n_bad++;
         $display("FAIL err_first_ver: %b required 1", obs_err_ver1); end
      n_cmp++; if (obs_err_done1 !== 1'b1 || error1 !== 1'b1) begin n_bad++;
         $display("FAIL err_sticky: at_done=%b after=%b required 1", obs_err_done1, error1); end
      n_cmp++; if (obs_lat1 != 2 * N + 1) begin n_bad++;
         $display("FAIL stuck_lat1: %0d required %0d", obs_lat1, 2 * N + 1); end
      n_cmp++; if (error0 !== 1'b0) begin n_bad++;
         $display("FAIL err_single_pass: %b required 0", error0); end
      stuck = 1'b0;
      test_load(8'h3C);   // fresh start clears error and verifies cleanly
   endtask

   task automatic test_stall();
      pulse(8'hA5);
      observe(4);
      n_cmp++; if (obs_lo0 != 3) begin n_bad++;
         $display("FAIL stall_en_low: %0d cycles required 3", obs_lo0); end
      n_cmp++; if (obs_hold_ok !== 1'b1) begin n_bad++;
         $display("FAIL stall_hold: config_in changed while stalled"); end
      n_cmp++; if (obs_lat0 != N + 4 || obs_lat1 != 2 * N + 4) begin n_bad++;
         $display("FAIL stall_lat: %0d/%0d required %0d/%0d", obs_lat0, obs_lat1, N + 4, 2 * N + 4); end
      n_cmp++; if (chain0 !== 8'hA5 || chain1 !== 8'hA5 || error1 !== 1'b0) begin n_bad++;
         $display("FAIL stall_chain: %h %h err=%b required a5 a5 0", chain0, chain1, error1); end
   endtask

   task automatic test_back_to_back_reset();
      int dn;
      pulse(8'hC3);
      @(negedge clk);
      start    = 1'b1;          // must be ignored while busy
      cfg_word = 8'hFF;
      @(negedge clk);
      start    = 1'b0;
      cfg_word = '0;
      n_cmp++; if (busy0 !== 1'b1) begin n_bad++;
         $display("FAIL busy_hold: %b required 1", busy0); end
      for (int k = 0; k < 20 && q0.size() > N - 5; k++) begin @(negedge clk); #1; end
      n_cmp++; if (q0.size() != N - 5) begin n_bad++;
         $display("FAIL reach_bit5: %0d bits left required %0d", q0.size(), N - 5); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_cmp++; if ({busy0, en0, busy1, en1, done0, done1} !== 6'b0) begin n_bad++;
         $display("FAIL mid_reset: busy/en/done=%b required 000000", {busy0, en0, busy1, en1, done0, done1}); end
      q0.delete();
      q1.delete();
      dn = 0;
      repeat (30) begin @(negedge clk); if (done0 || done1 || en0 || en1) dn++; end
      n_cmp++; if (dn != 0) begin n_bad++;
         $display("FAIL after_reset_quiet: %0d active cycles required 0", dn); end
      test_load(8'h5A);
   endtask

   initial begin
      test_reset();
      test_load(8'hA5);
      test_load(8'h3C);
      test_verify_stuck();
      test_stall();
      test_back_to_back_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
